// File: rtl/kp_pkg.sv
// Shared types and helpers for the keypad digit-entry block.
// Decodes the active-low priority-encoder output into a key number.
package kp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HELD = 2'd2
    } kp_state_e;

    localparam logic [3:0] KP_NOKEY  = 4'd0;
    localparam logic [3:0] KP_MAXKEY = 4'd9;

    // Codes above 9 are not real keys and read as "no key".
    function automatic logic [3:0] kp_decode(input logic [3:0] y_n);
        logic [3:0] code;
        code = ~y_n;
        return (code > KP_MAXKEY) ? KP_NOKEY : code;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Press/release debouncer: registers the decoded key code and pulses fire
// once per debounced press, with the qualified digit on cand.
module kp_debounce
    import kp_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Y_n,
    output logic       fire,
    output logic [3:0] cand
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEB_CYC);
    localparam logic [CW-1:0] CNT_REL  = CW'(DEB_CYC - 1);

    logic [3:0]    s_code;
    kp_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          armed_q, armed_d;

    // The sampler ignores reset so a key held through reset still reads as held.
    always_ff @(posedge clk) begin
        s_code <= kp_decode(Y_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= KP_NOKEY;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        armed_d = armed_q;
        fire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // After reset a key only counts once the pad has been seen empty.
                if (s_code == KP_NOKEY) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    cand_d  = s_code;
                    cnt_d   = CW'(1);
                    state_d = QUAL;
                end
            end
            QUAL: begin
                if (s_code != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_FIRE) begin
                    fire    = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (s_code != KP_NOKEY) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_REL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cand = cand_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad front end: debounced key events on a valid/ready port plus a
// calculator-style BCD entry buffer with sticky overflow/overrun flags.
module keypad_digit_entry
    import kp_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DEB_CYC = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   Y_n,
    input  logic                         clr,
    output logic                         key_valid,
    output logic [3:0]                   key_digit,
    input  logic                         key_ready,
    output logic [4*DIGITS-1:0]          digits_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic                         full,
    output logic                         overflow,
    output logic                         overrun
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    logic       fire;
    logic [3:0] cand;

    logic                 valid_q, valid_d;
    logic [3:0]           digit_q, digit_d;
    logic [4*DIGITS-1:0]  buf_q, buf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic                 ovr_q, ovr_d;
    logic [4*DIGITS+3:0]  shifted;

    kp_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .Y_n  (Y_n),
        .fire (fire),
        .cand (cand)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            digit_q <= KP_NOKEY;
            buf_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            digit_q <= digit_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;
        shifted = {buf_q, cand};

        // A pending unaccepted event wins over a new one.
        if (fire) begin
            if (!valid_q || key_ready) begin
                valid_d = 1'b1;
                digit_d = cand;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end

        if (fire) begin
            if (cnt_q < CNT_MAX) begin
                buf_d = shifted[4*DIGITS-1:0];
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            ovr_d = 1'b0;
        end

        full_d = (cnt_d == CNT_MAX);
    end

    assign key_valid  = valid_q;
    assign key_digit  = digit_q;
    assign digits_bcd = buf_q;
    assign digit_cnt  = cnt_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: directed scenarios plus randomized press/bounce
// segments checked against a segment-level model of press and release rules.
module tb_keypad_digit_entry;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DEB_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  Y_n = 4'hF;
    logic        clr = 1'b0;
    logic        key_ready = 1'b1;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic [15:0] digits_bcd;
    logic [2:0]  digit_cnt;
    logic        full;
    logic        overflow;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    logic [3:0] seen[$];

    keypad_digit_entry #(
        .DIGITS  (DIGITS),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Y_n        (Y_n),
        .clr        (clr),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_ready  (key_ready),
        .digits_bcd (digits_bcd),
        .digit_cnt  (digit_cnt),
        .full       (full),
        .overflow   (overflow),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Every handshake is one delivered event.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) seen.push_back(key_digit);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int n);
        Y_n = ~d;
        step(n);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", key_valid); end
        total++; if (key_digit !== 4'h0) begin bad++; $display("FAIL reset_digit: got %0h want 0", key_digit); end
        total++; if (digits_bcd !== 16'h0) begin bad++; $display("FAIL reset_bcd: got %0h want 0", digits_bcd); end
        total++; if (digit_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", digit_cnt); end
        total++; if ({full, overflow, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {full, overflow, overrun}); end
    endtask

    task automatic test_single_press();
        seen.delete();
        Y_n = 4'b1100;
        step(5);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %0h want 0", key_valid); end
        step(1);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %0h want 1", key_valid); end
        total++; if (key_digit !== 4'd3) begin bad++; $display("FAIL single_digit: got %0h want 3", key_digit); end
        step(1);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_pulse: got %0h want 0", key_valid); end
        step(3);
        press(4'd0, 8);
        total++; if (seen.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", seen.size()); end
        total++; if (digits_bcd !== 16'h0003) begin bad++; $display("FAIL single_bcd: got %0h want 0003", digits_bcd); end
        total++; if (digit_cnt !== 3'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", digit_cnt); end
    endtask

    task automatic test_bounce();
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            Y_n = 4'b1010;
            step(2);
            Y_n = 4'b1111;
            step(2);
        end
        total++; if (seen.size() !== 0 || key_valid !== 1'b0) begin bad++; $display("FAIL bounce_quiet: got %0d events want 0", seen.size()); end
        press(4'd5, 8);
        press(4'd0, 8);
        total++; if (seen.size() !== 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", seen.size()); end
        total++; if ((seen.size() > 0 ? seen[0] : 4'hF) !== 4'd5) begin bad++; $display("FAIL bounce_digit: got %0h want 5", seen.size() > 0 ? seen[0] : 4'hF); end
        total++; if (digits_bcd !== 16'h0035) begin bad++; $display("FAIL bounce_bcd: got %0h want 0035", digits_bcd); end
    endtask

    task automatic test_hold();
        seen.delete();
        press(4'd7, 40);
        press(4'd2, 10);
        total++; if (seen.size() !== 1) begin bad++; $display("FAIL hold_single: got %0d want 1", seen.size()); end
        press(4'd0, 6);
        press(4'd2, 8);
        press(4'd0, 8);
        total++; if (seen.size() !== 2) begin bad++; $display("FAIL hold_count: got %0d want 2", seen.size()); end
        total++; if ((seen.size() > 1 ? {seen[0], seen[1]} : 8'hFF) !== 8'h72) begin bad++; $display("FAIL hold_digits: got %0h want 72", seen.size() > 1 ? {seen[0], seen[1]} : 8'hFF); end
        total++; if (digits_bcd !== 16'h3572) begin bad++; $display("FAIL hold_bcd: got %0h want 3572", digits_bcd); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL hold_full: got %0h want 1", full); end
    endtask

    task automatic test_fill_overflow();
        pulse_clr();
        total++; if ({digits_bcd, digit_cnt, full, overflow} !== 21'h0) begin bad++; $display("FAIL fill_clr0: got %0h want 0", {digits_bcd, digit_cnt, full, overflow}); end
        seen.delete();
        for (int k = 1; k <= 5; k++) begin
            press(4'(k), 8);
            press(4'd0, 6);
            if (k == 4) begin
                total++; if ({full, overflow} !== 2'b10) begin bad++; $display("FAIL fill_four_flags: got %b want 10", {full, overflow}); end
            end
        end
        total++; if (digits_bcd !== 16'h1234) begin bad++; $display("FAIL fill_bcd: got %0h want 1234", digits_bcd); end
        total++; if ({digit_cnt, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin bad++; $display("FAIL fill_flags: got %0h want 13", {digit_cnt, full, overflow}); end
        total++; if ((seen.size() == 5 ? seen[4] : 4'hF) !== 4'd5) begin bad++; $display("FAIL fill_event5: got size %0d want 5th event 5", seen.size()); end
        pulse_clr();
        total++; if ({digits_bcd, digit_cnt, full, overflow} !== 21'h0) begin bad++; $display("FAIL fill_clr: got %0h want 0", {digits_bcd, digit_cnt, full, overflow}); end
    endtask

    task automatic test_backpressure();
        seen.delete();
        key_ready = 1'b0;
        press(4'd8, 8);
        press(4'd0, 6);
        press(4'd9, 8);
        press(4'd0, 6);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0h want 1", key_valid); end
        total++; if (key_digit !== 4'd8) begin bad++; $display("FAIL bp_digit: got %0h want 8", key_digit); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %0h want 1", overrun); end
        total++; if (digits_bcd !== 16'h0089) begin bad++; $display("FAIL bp_bcd: got %0h want 0089", digits_bcd); end
        key_ready = 1'b1;
        step(1);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0h want 0", key_valid); end
        total++; if (seen.size() !== 1) begin bad++; $display("FAIL bp_handshakes: got %0d want 1", seen.size()); end
    endtask

    task automatic test_reset_mid_qual();
        seen.delete();
        Y_n = ~4'd6;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++; if ({key_valid, key_digit, digits_bcd, digit_cnt, full, overflow, overrun} !== 27'h0) begin bad++; $display("FAIL rstq_outputs: got %0h want 0", {key_valid, key_digit, digits_bcd, digit_cnt, full, overflow, overrun}); end
        step(15);
        total++; if (seen.size() !== 0 || key_valid !== 1'b0) begin bad++; $display("FAIL rstq_noevent: got %0d events want 0", seen.size()); end
        press(4'd0, 6);
        press(4'd6, 8);
        press(4'd0, 8);
        total++; if ((seen.size() == 1 ? seen[0] : 4'hF) !== 4'd6) begin bad++; $display("FAIL rstq_repress: got size %0d want one event 6", seen.size()); end
    endtask

    task automatic test_random(input int round);
        logic [3:0]  exp_ev[$];
        logic [15:0] exp_bcd;
        logic [3:0]  d;
        int          len;
        int          r;
        int          n;
        bit          released;
        pulse_clr();
        seen.delete();
        key_ready = 1'b1;
        released  = 1'b1;
        for (int s = 0; s < 40; s++) begin
            d   = 4'($urandom_range(1, 9));
            len = $urandom_range(1, 8);
            press(d, len);
            if (released && len >= DEB_CYC + 1) begin
                exp_ev.push_back(d);
                released = 1'b0;
            end
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                r   = $urandom_range(0, 6);
                Y_n = (r == 6) ? 4'hF : 4'(r);
                step(1);
            end
            if (!released && len >= DEB_CYC) released = 1'b1;
        end
        press(4'd0, 10);
        n       = exp_ev.size();
        exp_bcd = 16'h0;
        for (int i = 0; i < n && i < DIGITS; i++) exp_bcd = exp_bcd * 16 + 16'(exp_ev[i]);
        total++; if (seen.size() !== n) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", round, seen.size(), n); end
        for (int i = 0; i < n && i < seen.size(); i++) begin
            total++; if (seen[i] !== exp_ev[i]) begin bad++; $display("FAIL rand%0d_ev%0d: got %0h want %0h", round, i, seen[i], exp_ev[i]); end
        end
        total++; if (digits_bcd !== exp_bcd) begin bad++; $display("FAIL rand%0d_bcd: got %0h want %0h", round, digits_bcd, exp_bcd); end
        total++; if (digit_cnt !== 3'((n < DIGITS) ? n : DIGITS)) begin bad++; $display("FAIL rand%0d_cnt: got %0d want %0d", round, digit_cnt, (n < DIGITS) ? n : DIGITS); end
        total++; if ({full, overflow} !== {n >= DIGITS, n > DIGITS}) begin bad++; $display("FAIL rand%0d_flags: got %b want %b", round, {full, overflow}, {n >= DIGITS, n > DIGITS}); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rand%0d_overrun: got %0h want 0", round, overrun); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_hold();
        test_fill_overflow();
        test_backpressure();
        test_reset_mid_qual();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
